// File: rtl/vga_mem_pkg.sv
// Types and default geometry shared by the VGA memory path
// (pixel fetcher, memory address controller, BRAM wrapper).
package vga_mem_pkg;

  localparam int unsigned VGA_PXL_WIDTH   = 1;
  localparam int unsigned VGA_PXL_PER_ROW = 8;
  localparam int unsigned VGA_MEM_DEPTH   = 38400;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    STREAM
  } fetch_state_t;

  // Travels alongside an outstanding read; epoch marks the frame it belongs to.
  typedef struct packed {
    logic vld;
    logic bid;
    logic epoch;
  } rd_tag_t;

endpackage

// File: rtl/vga_rd_tag_pipe.sv
// Delay line that carries read tags so each one emerges in the cycle its
// memory data returns; a flush drops every read still in flight.
module vga_rd_tag_pipe
  import vga_mem_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    flush_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [RD_LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/vga_pxl_fetch.sv
// Double-buffered row fetcher: prefetches two memory words per frame and
// streams their pixels LSB-first, refilling each buffer as it drains.
module vga_pxl_fetch
  import vga_mem_pkg::*;
#(
  parameter int unsigned PXL_WIDTH   = VGA_PXL_WIDTH,
  parameter int unsigned PXL_PER_ROW = VGA_PXL_PER_ROW,
  parameter int unsigned MEM_DEPTH   = VGA_MEM_DEPTH,
  parameter int unsigned RD_LATENCY  = 1,
  localparam int unsigned MEM_WIDTH      = PXL_PER_ROW * PXL_WIDTH,
  localparam int unsigned MEM_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      frame_start_i,
  input  logic                      pxl_req_i,
  output logic                      mem_en_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [MEM_WIDTH-1:0]      mem_data_i,
  output logic [PXL_WIDTH-1:0]      pxl_o,
  output logic                      pxl_vld_o,
  output logic                      underrun_o
);

  localparam int unsigned IDX_W = $clog2(PXL_PER_ROW);
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(PXL_PER_ROW - 1);

  // A buffer must be refilled before the other one drains.
  if (RD_LATENCY < 1 || RD_LATENCY > 3 || PXL_PER_ROW < RD_LATENCY + 2) begin : g_bad_cfg
    $error("vga_pxl_fetch: RD_LATENCY must be 1..3 and PXL_PER_ROW >= RD_LATENCY+2");
  end

  fetch_state_t state_q, state_d;

  logic [MEM_WIDTH-1:0]      row_q [2];
  logic [1:0]                rvld_q;
  logic                      act_q;
  logic [IDX_W-1:0]          k_q;
  logic                      epoch_q;
  logic                      pf_done_q;
  logic                      mem_en_q, mem_en_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                      mem_bid_q, mem_bid_d;
  logic [PXL_WIDTH-1:0]      pxl_q;
  logic                      pxl_vld_q;
  logic                      underrun_q;

  logic                      consume, row_end, wr_en;
  logic [1:0]                wr_mask;
  logic [MEM_ADDR_WIDTH-1:0] addr_inc;
  rd_tag_t                   tag_in, tag_out;

  assign tag_in = '{vld: mem_en_q, bid: mem_bid_q, epoch: epoch_q};

  vga_rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_tag_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(frame_start_i),
    .tag_i  (tag_in),
    .tag_o  (tag_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start_i) begin
      state_d = PREFETCH;
    end else if (state_q == PREFETCH && (rvld_q | wr_mask) == 2'b11) begin
      state_d = STREAM;
    end
  end

  always_comb begin
    addr_inc = (mem_addr_q == LAST_ADDR) ? '0 : mem_addr_q + MEM_ADDR_WIDTH'(1);
    consume  = pxl_req_i && !frame_start_i && state_q == STREAM && rvld_q[act_q];
    row_end  = consume && (k_q == LAST_IDX);
    wr_en    = tag_out.vld && (tag_out.epoch == epoch_q) && !frame_start_i;
    wr_mask  = '0;
    if (wr_en) wr_mask[tag_out.bid] = 1'b1;

    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_bid_d  = mem_bid_q;
    if (frame_start_i) begin
      mem_en_d   = 1'b1;
      mem_addr_d = '0;
      mem_bid_d  = 1'b0;
    end else if (state_q == PREFETCH && !pf_done_q) begin
      mem_en_d   = 1'b1;
      mem_addr_d = addr_inc;
      mem_bid_d  = 1'b1;
    end else if (row_end) begin
      mem_en_d   = 1'b1;
      mem_addr_d = addr_inc;
      mem_bid_d  = act_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q[0]   <= '0;
      row_q[1]   <= '0;
      rvld_q     <= '0;
      act_q      <= 1'b0;
      k_q        <= '0;
      epoch_q    <= 1'b0;
      pf_done_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_bid_q  <= 1'b0;
      pxl_q      <= '0;
      pxl_vld_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      mem_en_q <= mem_en_d;
      if (mem_en_d) begin
        mem_addr_q <= mem_addr_d;
        mem_bid_q  <= mem_bid_d;
      end

      if (frame_start_i) begin
        rvld_q    <= '0;
        act_q     <= 1'b0;
        k_q       <= '0;
        epoch_q   <= ~epoch_q;
        pf_done_q <= 1'b0;
      end else begin
        if (state_q == PREFETCH) pf_done_q <= 1'b1;
        if (row_end) begin
          k_q           <= '0;
          act_q         <= ~act_q;
          rvld_q[act_q] <= 1'b0;
        end else if (consume) begin
          k_q <= k_q + IDX_W'(1);
        end
        // The returning word always targets the buffer freed earlier, never the active one.
        if (wr_en) begin
          row_q[tag_out.bid]  <= mem_data_i;
          rvld_q[tag_out.bid] <= 1'b1;
        end
      end

      if (consume) begin
        pxl_q     <= row_q[act_q][int'(k_q) * PXL_WIDTH +: PXL_WIDTH];
        pxl_vld_q <= 1'b1;
      end else if (pxl_req_i) begin
        pxl_q     <= '0;
        pxl_vld_q <= 1'b0;
      end else begin
        pxl_vld_q <= 1'b0;
      end

      if (frame_start_i)  underrun_q <= 1'b0;
      else if (pxl_req_i && !consume) underrun_q <= 1'b1;
    end
  end

  assign mem_en_o   = mem_en_q;
  assign mem_addr_o = mem_addr_q;
  assign pxl_o      = pxl_q;
  assign pxl_vld_o  = pxl_vld_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_vga_pxl_fetch.sv
// Scoreboard bench for vga_pxl_fetch: 3-bit pixels, 8 per word, 4-word frame,
// 3-cycle memory latency, checked against a frame/pixel-count reference model.
module tb_vga_pxl_fetch;

  localparam int unsigned W  = 3;
  localparam int unsigned P  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned L  = 3;
  localparam int unsigned MW = W * P;
  localparam int unsigned AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst, fs, req;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_data;
  logic [W-1:0]  pxl;
  logic          pxl_vld, underrun;

  always #5 clk = ~clk;

  vga_pxl_fetch #(
    .PXL_WIDTH  (W),
    .PXL_PER_ROW(P),
    .MEM_DEPTH  (D),
    .RD_LATENCY (L)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .frame_start_i(fs),
    .pxl_req_i    (req),
    .mem_en_o     (mem_en),
    .mem_addr_o   (mem_addr),
    .mem_data_i   (mem_data),
    .pxl_o        (pxl),
    .pxl_vld_o    (pxl_vld),
    .underrun_o   (underrun)
  );

  // Memory with fixed read latency; returns junk whenever no read is due.
  logic [MW-1:0] mem [D];
  logic          pv [L];
  logic [AW-1:0] pa [L];
  logic [MW-1:0] junk;

  always @(posedge clk) begin
    junk <= MW'($urandom);
    if (rst) begin
      for (int i = 0; i < L; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= mem_en;
      pa[0] <= mem_addr;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  assign mem_data = pv[L-1] ? mem[pa[L-1]] : junk;

  typedef struct {
    bit           vld;
    logic [W-1:0] pxl;
  } pexp_t;

  pexp_t        pxq [$];
  int           adq [$];
  int           checks = 0;
  int           passes = 0;
  int           cyc = 0;
  int           start_cyc = 1 << 30;
  int           last_fs = -10;
  int           pcount = 0;
  bit           exp_under = 1'b0;
  bit           mon_en = 1'b0;
  bit           req_seen = 1'b0;
  logic [W-1:0] last_pxl = '0;
  int           last_addr = 0;
  pexp_t        mon_e;
  int           mon_a;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // One cycle of stimulus; the model predicts the response from frame and pixel counts.
  task automatic step(input bit f, input bit r);
    pexp_t         e;
    bit            u;
    int            row, k;
    logic [MW-1:0] word;
    fs  = f;
    req = r;
    u   = exp_under;
    if (r) begin
      if (!f && cyc >= start_cyc) begin
        row    = pcount / P;
        k      = pcount % P;
        word   = mem[row % D];
        e.vld  = 1'b1;
        e.pxl  = word[k*W +: W];
        if (k == P - 1) adq.push_back((row + 2) % D);
        pcount++;
      end else begin
        e.vld = 1'b0;
        e.pxl = '0;
        if (!f) u = 1'b1;
      end
      pxq.push_back(e);
    end
    if (f) begin
      if (last_fs == cyc - 1) void'(adq.pop_back());
      adq.push_back(0);
      adq.push_back(1);
      start_cyc = cyc + 3 + L;
      pcount    = 0;
      last_fs   = cyc;
      u         = 1'b0;
    end
    @(posedge clk);
    exp_under = u;
    cyc++;
    #1;
  endtask

  always @(posedge clk) req_seen <= req && !rst;

  always @(negedge clk) begin
    if (mon_en) begin
      if (req_seen) begin
        chk("pxl_expected", int'(pxq.size() != 0), 1);
        if (pxq.size() != 0) begin
          mon_e = pxq.pop_front();
          chk("pxl_vld", int'(pxl_vld), int'(mon_e.vld));
          chk("pxl_val", int'(pxl), int'(mon_e.pxl));
          last_pxl = mon_e.pxl;
        end
      end else begin
        chk("idle_vld", int'(pxl_vld), 0);
        chk("pxl_hold", int'(pxl), int'(last_pxl));
      end
      chk("underrun", int'(underrun), int'(exp_under));
      if (mem_en) begin
        chk("rd_expected", int'(adq.size() != 0), 1);
        if (adq.size() != 0) begin
          mon_a = adq.pop_front();
          chk("rd_addr", int'(mem_addr), mon_a);
          last_addr = mon_a;
        end
      end else begin
        chk("addr_hold", int'(mem_addr), last_addr);
      end
    end
  end

  initial begin
    bit f, r;
    int dens;
    rst = 1'b1;
    fs  = 1'b1;
    req = 1'b1;
    for (int i = 0; i < D; i++) mem[i] = MW'($urandom);
    mem[0] = 24'o76543210;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_pxl", int'(pxl), 0);
    chk("rst_pxl_vld", int'(pxl_vld), 0);
    chk("rst_underrun", int'(underrun), 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    fs     = 1'b0;
    req    = 1'b0;
    mon_en = 1'b1;

    step(0, 0); step(0, 1); step(0, 1); step(0, 0);
    step(1, 1);
    step(0, 1);
    repeat (30) step(0, 1);

    step(1, 0);
    repeat (3 + L) step(0, 0);
    repeat (P * 5 + 3) step(0, 1);

    step(1, 0);
    repeat (3 + L) step(0, 0);
    repeat (P + 3) step(0, 1);
    step(1, 0);
    repeat (3 + L) step(0, 0);
    repeat (P * 2) step(0, 1);

    step(1, 0);
    step(1, 0);
    repeat (12) step(0, 1'($urandom_range(0, 1)));

    for (int seg = 0; seg < 60; seg++) begin
      dens = $urandom_range(1, 4);
      for (int i = 0; i < 50; i++) begin
        f = ($urandom_range(0, 149) == 0);
        r = ($urandom_range(1, 4) <= dens);
        if (f) for (int j = 0; j < D; j++) mem[j] = MW'($urandom);
        step(f, r);
      end
    end

    repeat (10) step(0, 0);
    chk("pxl_queue_drained", pxq.size(), 0);
    chk("rd_queue_drained", adq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
